// File: rtl/otter_stream_pkg.sv
// Shared lane count, lane-select type and one-hot decode for the stream demux blocks.
package otter_stream_pkg;

  localparam int NUM_LANES = 4;

  typedef logic [1:0] lane_sel_t;

  function automatic logic [NUM_LANES-1:0] lane_onehot(input lane_sel_t sel);
    logic [NUM_LANES-1:0] oh;
    oh      = '0;
    oh[sel] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/demux_lane.sv
// One output lane: single-entry holding register plus saturating handshake counter.
// Write lands next cycle; wr_rdy is high when empty or draining this cycle (refill with no bubble).
module demux_lane #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_vld,
  input  logic [WIDTH-1:0] wr_dat,
  output logic             wr_rdy,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_dat,
  input  logic             out_rdy,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt
);

  logic             vld_q, vld_d;
  logic [WIDTH-1:0] dat_q, dat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_hs;

  assign out_hs  = vld_q && out_rdy;
  assign wr_rdy  = !vld_q || out_rdy;
  assign out_vld = vld_q;
  assign out_dat = dat_q;
  assign cnt     = cnt_q;

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    cnt_d = cnt_q;
    if (out_hs) vld_d = 1'b0;
    // A refill in the same cycle as a drain overrides the clear.
    if (wr_vld) begin
      vld_d = 1'b1;
      dat_d = wr_dat;
    end
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (out_hs && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= 1'b0;
      dat_q <= '0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/stream_demux4.sv
// Routes one input stream to four single-entry output lanes by IN_SEL, latency 1.
// IN_READY follows only the selected lane, so a stalled lane never blocks the others.
module stream_demux4
  import otter_stream_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 IN_VALID,
  input  logic [WIDTH-1:0]     IN_DATA,
  input  lane_sel_t            IN_SEL,
  output logic                 IN_READY,
  output logic [NUM_LANES-1:0] OUT_VALID,
  output logic [WIDTH-1:0]     OUT_DATA0,
  output logic [WIDTH-1:0]     OUT_DATA1,
  output logic [WIDTH-1:0]     OUT_DATA2,
  output logic [WIDTH-1:0]     OUT_DATA3,
  input  logic [NUM_LANES-1:0] OUT_READY,
  input  logic                 CNT_CLR,
  output logic [CNT_W-1:0]     CNT0,
  output logic [CNT_W-1:0]     CNT1,
  output logic [CNT_W-1:0]     CNT2,
  output logic [CNT_W-1:0]     CNT3
);

  logic [NUM_LANES-1:0]            lane_rdy;
  logic [NUM_LANES-1:0]            lane_wr;
  logic [NUM_LANES-1:0][WIDTH-1:0] lane_dat;
  logic [NUM_LANES-1:0][CNT_W-1:0] lane_cnt;

  assign IN_READY = !RST && lane_rdy[IN_SEL];

  always_comb begin
    lane_wr = '0;
    if (IN_VALID && IN_READY) lane_wr = lane_onehot(IN_SEL);
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    demux_lane #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
    ) u_lane (
      .clk     (CLK),
      .rst     (RST),
      .wr_vld  (lane_wr[i]),
      .wr_dat  (IN_DATA),
      .wr_rdy  (lane_rdy[i]),
      .out_vld (OUT_VALID[i]),
      .out_dat (lane_dat[i]),
      .out_rdy (OUT_READY[i]),
      .cnt_clr (CNT_CLR),
      .cnt     (lane_cnt[i])
    );
  end

  assign OUT_DATA0 = lane_dat[0];
  assign OUT_DATA1 = lane_dat[1];
  assign OUT_DATA2 = lane_dat[2];
  assign OUT_DATA3 = lane_dat[3];
  assign CNT0      = lane_cnt[0];
  assign CNT1      = lane_cnt[1];
  assign CNT2      = lane_cnt[2];
  assign CNT3      = lane_cnt[3];

endmodule

// File: tb/tb_stream_demux4.sv
// Directed and randomized checks of stream_demux4 against a per-lane slot/counter model.
module tb_stream_demux4;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        IN_VALID = 1'b0;
  logic [31:0] IN_DATA = '0;
  logic [1:0]  IN_SEL = '0;
  logic        IN_READY;
  logic [3:0]  OUT_VALID;
  logic [31:0] OUT_DATA0, OUT_DATA1, OUT_DATA2, OUT_DATA3;
  logic [3:0]  OUT_READY = '0;
  logic        CNT_CLR = 1'b0;
  logic [7:0]  CNT0, CNT1, CNT2, CNT3;

  int n_vec = 0;
  int n_err = 0;

  // Model: one slot per lane (occupied flag + word) and a handshake count.
  bit          m_vld [4];
  logic [31:0] m_dat [4];
  int          m_cnt [4];

  wire [31:0] out_dat [4];
  wire [7:0]  cnt_a   [4];
  assign out_dat[0] = OUT_DATA0;
  assign out_dat[1] = OUT_DATA1;
  assign out_dat[2] = OUT_DATA2;
  assign out_dat[3] = OUT_DATA3;
  assign cnt_a[0] = CNT0;
  assign cnt_a[1] = CNT1;
  assign cnt_a[2] = CNT2;
  assign cnt_a[3] = CNT3;

  stream_demux4 #(.WIDTH(32), .CNT_W(8)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_DATA(IN_DATA), .IN_SEL(IN_SEL),
    .IN_READY(IN_READY), .OUT_VALID(OUT_VALID),
    .OUT_DATA0(OUT_DATA0), .OUT_DATA1(OUT_DATA1), .OUT_DATA2(OUT_DATA2), .OUT_DATA3(OUT_DATA3),
    .OUT_READY(OUT_READY), .CNT_CLR(CNT_CLR),
    .CNT0(CNT0), .CNT1(CNT1), .CNT2(CNT2), .CNT3(CNT3)
  );

  initial forever #5 CLK = ~CLK;

  function automatic bit exp_ready();
    return !RST && (!m_vld[IN_SEL] || OUT_READY[IN_SEL]);
  endfunction

  // Advance one clock, updating the model from the inputs currently driven.
  task automatic tick();
    bit          rdy;
    bit          nv [4];
    logic [31:0] nd [4];
    int          nc [4];
    rdy = exp_ready();
    for (int n = 0; n < 4; n++) begin
      bit drain, fill;
      drain = m_vld[n] && OUT_READY[n];
      fill  = IN_VALID && rdy && (IN_SEL == n);
      nv[n] = fill ? 1'b1 : (drain ? 1'b0 : m_vld[n]);
      nd[n] = fill ? IN_DATA : m_dat[n];
      nc[n] = CNT_CLR ? 0 : (drain ? ((m_cnt[n] + 1 > 255) ? 255 : m_cnt[n] + 1) : m_cnt[n]);
      if (RST) begin
        nv[n] = 1'b0;
        nd[n] = '0;
        nc[n] = 0;
      end
    end
    @(posedge CLK);
    #1;
    for (int n = 0; n < 4; n++) begin
      m_vld[n] = nv[n];
      m_dat[n] = nd[n];
      m_cnt[n] = nc[n];
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    IN_VALID = 1'b1;
    OUT_READY = 4'hF;
    tick();
    tick();
    #1;
    n_vec++;
    if (IN_READY !== 1'b0) begin n_err++; $display("FAIL reset_in_ready got %b exp 0", IN_READY); end
    n_vec++;
    if (OUT_VALID !== 4'b0000) begin n_err++; $display("FAIL reset_out_valid got %b exp 0000", OUT_VALID); end
    for (int n = 0; n < 4; n++) begin
      n_vec++;
      if (out_dat[n] !== 32'h0 || cnt_a[n] !== 8'd0) begin
        n_err++; $display("FAIL reset_lane%0d data %h cnt %0d exp 0/0", n, out_dat[n], cnt_a[n]);
      end
    end
    RST = 1'b0;
    IN_VALID = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    IN_VALID = 1'b1; IN_SEL = 2'd2; IN_DATA = 32'hDEADBEEF; OUT_READY = 4'hF;
    #1;
    n_vec++;
    if (IN_READY !== 1'b1) begin n_err++; $display("FAIL basic_in_ready got %b exp 1", IN_READY); end
    tick();
    IN_VALID = 1'b0;
    n_vec++;
    if (OUT_VALID !== 4'b0100) begin n_err++; $display("FAIL basic_out_valid got %b exp 0100", OUT_VALID); end
    n_vec++;
    if (OUT_DATA2 !== 32'hDEADBEEF) begin n_err++; $display("FAIL basic_data2 got %h exp deadbeef", OUT_DATA2); end
    tick();
    n_vec++;
    if (CNT2 !== 8'd1 || OUT_VALID !== 4'b0000) begin
      n_err++; $display("FAIL basic_cnt2 got %0d vld %b exp 1 / 0000", CNT2, OUT_VALID);
    end
  endtask

  task automatic test_backpressure();
    OUT_READY = 4'b1101;
    IN_VALID = 1'b1; IN_SEL = 2'd1; IN_DATA = 32'h11;
    tick();
    IN_DATA = 32'h22;
    #1;
    n_vec++;
    if (IN_READY !== 1'b0) begin n_err++; $display("FAIL bp_in_ready_stall got %b exp 0", IN_READY); end
    tick();
    n_vec++;
    if (OUT_DATA1 !== 32'h11 || OUT_VALID[1] !== 1'b1) begin
      n_err++; $display("FAIL bp_hold got %h vld %b exp 11 / 1", OUT_DATA1, OUT_VALID[1]);
    end
    OUT_READY[1] = 1'b1;
    #1;
    n_vec++;
    if (IN_READY !== 1'b1) begin n_err++; $display("FAIL bp_in_ready_release got %b exp 1", IN_READY); end
    tick();
    IN_VALID = 1'b0;
    OUT_READY[1] = 1'b0;
    n_vec++;
    if (OUT_DATA1 !== 32'h22 || OUT_VALID[1] !== 1'b1) begin
      n_err++; $display("FAIL bp_refill got %h vld %b exp 22 / 1", OUT_DATA1, OUT_VALID[1]);
    end
    OUT_READY = 4'hF;
    tick();
    n_vec++;
    if (CNT1 !== 8'd2 || OUT_VALID !== 4'b0000) begin
      n_err++; $display("FAIL bp_drain cnt1 %0d vld %b exp 2 / 0000", CNT1, OUT_VALID);
    end
  endtask

  task automatic test_independent();
    OUT_READY = 4'b0000;
    IN_VALID = 1'b1; IN_SEL = 2'd0; IN_DATA = 32'hAA;
    tick();
    IN_SEL = 2'd3; IN_DATA = 32'h33;
    #1;
    n_vec++;
    if (IN_READY !== 1'b1) begin n_err++; $display("FAIL indep_in_ready got %b exp 1", IN_READY); end
    tick();
    IN_VALID = 1'b0;
    n_vec++;
    if (OUT_VALID !== 4'b1001 || OUT_DATA3 !== 32'h33 || OUT_DATA0 !== 32'hAA) begin
      n_err++; $display("FAIL indep_state vld %b d0 %h d3 %h exp 1001 aa 33", OUT_VALID, OUT_DATA0, OUT_DATA3);
    end
    OUT_READY = 4'hF;
    tick();
  endtask

  task automatic test_saturate();
    OUT_READY = 4'hF;
    IN_VALID = 1'b1; IN_SEL = 2'd0;
    for (int i = 0; i < 300; i++) begin
      IN_DATA = $urandom;
      tick();
    end
    n_vec++;
    if (CNT0 !== 8'd255) begin n_err++; $display("FAIL sat_reach got %0d exp 255", CNT0); end
    for (int i = 0; i < 5; i++) tick();
    n_vec++;
    if (CNT0 !== 8'd255) begin n_err++; $display("FAIL sat_hold got %0d exp 255", CNT0); end
    CNT_CLR = 1'b1;
    tick();
    CNT_CLR = 1'b0;
    IN_VALID = 1'b0;
    n_vec++;
    if (CNT0 !== 8'd0) begin n_err++; $display("FAIL sat_clear got %0d exp 0", CNT0); end
    tick();
    n_vec++;
    if (CNT0 !== 8'd1 || OUT_VALID !== 4'b0000) begin
      n_err++; $display("FAIL sat_after_clear got %0d vld %b exp 1 / 0000", CNT0, OUT_VALID);
    end
  endtask

  task automatic test_reset_mid();
    OUT_READY = 4'b0000;
    IN_VALID = 1'b1; IN_SEL = 2'd1; IN_DATA = 32'h5151;
    tick();
    IN_SEL = 2'd2; IN_DATA = 32'h5252;
    tick();
    n_vec++;
    if (OUT_VALID !== 4'b0110) begin n_err++; $display("FAIL rstmid_fill got %b exp 0110", OUT_VALID); end
    RST = 1'b1; OUT_READY = 4'hF; IN_SEL = 2'd3; IN_DATA = 32'h5353;
    #1;
    n_vec++;
    if (IN_READY !== 1'b0) begin n_err++; $display("FAIL rstmid_in_ready got %b exp 0", IN_READY); end
    tick();
    RST = 1'b0;
    IN_VALID = 1'b0;
    n_vec++;
    if (OUT_VALID !== 4'b0000 || CNT1 !== 8'd0 || CNT2 !== 8'd0) begin
      n_err++; $display("FAIL rstmid_state vld %b cnt1 %0d cnt2 %0d exp 0000 0 0", OUT_VALID, CNT1, CNT2);
    end
    n_vec++;
    if (OUT_DATA1 !== 32'h0 || OUT_DATA3 !== 32'h0) begin
      n_err++; $display("FAIL rstmid_data d1 %h d3 %h exp 0 0", OUT_DATA1, OUT_DATA3);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      IN_VALID  = ($urandom_range(0, 3) != 0);
      IN_SEL    = 2'($urandom_range(0, 3));
      IN_DATA   = $urandom;
      OUT_READY = 4'($urandom_range(0, 15));
      CNT_CLR   = ($urandom_range(0, 99) == 0);
      RST       = ($urandom_range(0, 299) == 0);
      #1;
      n_vec++;
      if (IN_READY !== exp_ready()) begin
        n_err++; $display("FAIL rand_in_ready cyc %0d got %b exp %b", i, IN_READY, exp_ready());
      end
      tick();
      for (int n = 0; n < 4; n++) begin
        n_vec++;
        if (OUT_VALID[n] !== m_vld[n] || out_dat[n] !== m_dat[n] || cnt_a[n] !== 8'(m_cnt[n])) begin
          n_err++;
          $display("FAIL rand_lane%0d cyc %0d vld %b data %h cnt %0d exp %b %h %0d",
                   n, i, OUT_VALID[n], out_dat[n], cnt_a[n], m_vld[n], m_dat[n], m_cnt[n]);
        end
      end
    end
    RST = 1'b0;
    CNT_CLR = 1'b0;
    IN_VALID = 1'b0;
  endtask

  initial begin
    for (int n = 0; n < 4; n++) begin
      m_vld[n] = 1'b0;
      m_dat[n] = '0;
      m_cnt[n] = 0;
    end
    #2;
    test_reset();
    test_basic();
    test_backpressure();
    test_independent();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/stream_demux4.md
STREAM_DEMUX4 -- requirements
Module: stream_demux4

Interface
REQ-001 Parameter WIDTH, default 32, data width of input and each output lane.
REQ-002 Parameter CNT_W, default 8, width of each per-lane transfer counter.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST  input  1  reset; synchronous, active-high.
REQ-005 IN_VALID  input  1  producer offers IN_DATA this cycle.
REQ-006 IN_DATA  input  WIDTH  payload to route.
REQ-007 IN_SEL  input  2  destination lane 0..3; sampled with IN_VALID.
REQ-008 IN_READY  output  1  block accepts IN_DATA this cycle.
REQ-009 OUT_VALID  output  4  per-lane holding register occupied.
REQ-010 OUT_DATA0, OUT_DATA1, OUT_DATA2, OUT_DATA3  output  WIDTH each  per-lane payload.
REQ-011 OUT_READY  input  4  per-lane consumer accepts.
REQ-012 CNT_CLR  input  1  clears all transfer counters.
REQ-013 CNT0, CNT1, CNT2, CNT3  output  CNT_W each  completed output handshakes per lane.

Function
REQ-014 Input handshake SHALL occur when IN_VALID && IN_READY on a rising edge; output handshake on lane n when OUT_VALID[n] && OUT_READY[n].
REQ-015 Each lane SHALL hold exactly one entry (valid flag + WIDTH data register).
REQ-016 IN_READY SHALL equal !RST && (!OUT_VALID[IN_SEL] || OUT_READY[IN_SEL]); it depends only on the selected lane, and the combinational path OUT_READY->IN_READY is permitted.
REQ-017 An accepted word SHALL appear on OUT_DATA[IN_SEL] with OUT_VALID[IN_SEL]=1 in the next cycle (latency 1); no other lane changes.
REQ-018 Simultaneous output handshake and input handshake on the same lane SHALL replace the entry (valid stays 1, data = new word); no bubble.
REQ-019 Output handshake without a refill SHALL clear OUT_VALID[n] next cycle.
REQ-020 While OUT_VALID[n] && !OUT_READY[n], OUT_DATA[n] SHALL remain stable.
REQ-021 Lanes SHALL drain independently; a stalled lane SHALL NOT block input words destined for other lanes.
REQ-022 OUT_DATA[n] while OUT_VALID[n]=0 SHALL retain its last value (no requirement beyond stability).
REQ-023 CNTn SHALL increment by 1 on each lane-n output handshake and saturate at 2^CNT_W-1.
REQ-024 CNT_CLR SHALL zero all counters next cycle; CNT_CLR concurrent with a handshake SHALL yield 0 (clear wins).
REQ-025 IN_SEL and IN_DATA while IN_VALID=0 SHALL be ignored.

Reset
REQ-026 RST SHALL, on the next rising edge, force OUT_VALID=4'b0000, all OUT_DATAn=0, all CNTn=0.
REQ-027 RST asserted mid-operation SHALL discard buffered entries; no output handshake is counted in that cycle.
REQ-028 IN_READY SHALL be 0 during any cycle RST is high; no word is accepted.

Structure
REQ-029 Shared package otter_stream_pkg SHALL hold constant NUM_LANES=4 and typedef lane_sel_t (2-bit).
REQ-030 One sub-module, demux_lane, SHALL implement one holding register plus its saturating counter; stream_demux4 instantiates four and decodes IN_SEL.
REQ-031 No latches; all storage in one always_ff per lane.

Verification
REQ-032 Reset then IN_VALID=1, IN_SEL=2, IN_DATA=0xDEADBEEF, OUT_READY=4'b1111 -> next cycle OUT_VALID=4'b0100, OUT_DATA2=0xDEADBEEF, cycle after CNT2=1.
REQ-033 OUT_READY[1]=0, send 0x11 to lane 1 then 0x22 to lane 1 -> IN_READY=0 on second word, OUT_DATA1 holds 0x11; raise OUT_READY[1] -> 0x22 accepted same cycle, OUT_DATA1=0x22 next cycle, no bubble.
REQ-034 Lane 0 stalled full; send 0x33 to lane 3 -> accepted immediately, OUT_VALID=4'b1001.
REQ-035 Lane 0 with OUT_READY=1, 300 back-to-back words -> CNT0 saturates at 255 and stays; then CNT_CLR with concurrent handshake -> CNT0=0.
REQ-036 Lanes 1 and 2 full, assert RST one cycle -> OUT_VALID=0, CNT1=CNT2=0, IN_READY=0 during RST cycle.
